lift_request_scheduler: RTL
===========================

// Module: lift_request_scheduler
// PURPOSE
//  Latches floor requests into a pending register and schedules them in SCAN (collective) order.
//  Drives target_floor/target_valid to the lift motion controller and times the door dwell.
//  Requests ahead in the current direction are served first; direction reverses only when none remain.
//  Sits between the floor call buttons and the motion FSM, replacing fixed lowest-floor-first priority.
// PARAMETERS
//  NUM_FLOORS   4   number of floors served; request and pending vectors are this wide
//  FLOOR_W      2   floor index width; must satisfy 2**FLOOR_W >= NUM_FLOORS
//  DOOR_CYCLES  8   door-open dwell in clk cycles; >= 1
//  PARK_CYCLES  64  idle cycles before homing to floor 0 (used only with the park feature)
// PORTS
//  clk             in   1           single clock; all logic on the rising edge
//  reset_n         in   1           synchronous, active-low reset
//  floor_req       in   NUM_FLOORS  bit i high in any cycle = call for floor i
//  emergency_stop  in   1           freezes scheduling while high
//  current_floor   in   FLOOR_W     floor position reported by the motion controller
//  at_floor        in   1           motion controller stationary at current_floor
//  target_floor    out  FLOOR_W     floor to travel to; valid only when target_valid is high
//  target_valid    out  1           request to move toward target_floor
//  dir_up          out  1           1 = scanning upward, 0 = downward
//  door_open       out  1           door held open at current_floor
//  pending         out  NUM_FLOORS  latched, unserved requests
// BEHAVIOUR
//  Reset: reset_n low at an edge -> pending=0, target_floor=0, target_valid=0, dir_up=1,
//    door_open=0, state=IDLE, all counters 0. Applies mid-travel or mid-dwell with no other effect.
//  Latching: pending[i] <= pending[i] | floor_req[i] each cycle, including in HALT.
//    A set pending bit stays set until it is served.
//    The only clear is the DOOR-entry clear; if floor_req is high in the same cycle, the clear wins.
//  ahead set: pending floors strictly above current_floor when dir_up=1, strictly below when dir_up=0.
//    "Nearest ahead" is the closest floor in the ahead set.
//  FSM states: IDLE, TRAVEL, DOOR, HALT. All outputs are registered.
//  IDLE:
//    pending[current_floor] && at_floor -> DOOR.
//    else ahead set non-empty -> TRAVEL with target = nearest ahead.
//    else any pending bit set -> toggle dir_up; go TRAVEL next cycle.
//    else stay in IDLE.
//  TRAVEL:
//    target_valid=1; target_floor re-evaluated every cycle as nearest ahead.
//    This lets a new call between current_floor and target be picked up en route.
//    at_floor && current_floor==target_floor -> DOOR.
//  DOOR:
//    Entry clears pending[current_floor], sets door_open=1, target_valid=0, loads dwell counter.
//    A new floor_req for current_floor during DOOR clears that bit and reloads the counter.
//    After DOOR_CYCLES cycles: door_open=0.
//    Then ahead set non-empty -> TRAVEL in the same direction.
//    else other pending bits -> toggle dir_up, then TRAVEL.
//    else -> IDLE.
//  HALT:
//    emergency_stop high in any state -> HALT next edge.
//    In HALT: target_valid=0, door_open=0, dwell counter cleared, pending and dir_up kept.
//    emergency_stop low -> IDLE.
//  Latency:
//    floor_req at edge n -> pending set after edge n.
//    From IDLE -> target_valid high after edge n+1.
//    A reversal adds 1 cycle.
//  Boundaries:
//    Top and bottom floors: ahead set empty, forcing reversal.
//    Request for the current floor while stationary opens the door with no travel.
//    floor_req bits >= NUM_FLOORS do not exist; floor indices above NUM_FLOORS-1 are never produced.
// CONFIGURATION
//  LIFT_HOME_PARK_EN defined:
//    An idle counter counts cycles in IDLE with pending==0.
//    At PARK_CYCLES -> TRAVEL to floor 0 with dir_up=0, without setting pending[0]; the door does not open.
//    Any request or emergency_stop resets the counter and takes priority.
//  LIFT_HOME_PARK_EN undefined:
//    The lift stays at its last floor indefinitely; no idle counter is built.
// STRUCTURE
//  Shared package lift_pkg: state encoding (IDLE/TRAVEL/DOOR/HALT),
//    NUM_FLOORS/FLOOR_W defaults, and function nearest_ahead(pending, floor, dir).
//    The motion controller will share this package.
//  One sub-module: lift_dwell_timer (load, reload, expire; width $clog2(DOOR_CYCLES+1)).
//  The FSM, pending register and scan selection live in the top module.
// TESTING
//  1 Reset: hold reset_n=0 3 cycles mid-TRAVEL -> all outputs at reset values, pending=0.
//  2 Same floor: at floor 0, at_floor=1, floor_req=4'b0001 one cycle
//    -> door_open high for 8 cycles, pending=0, target_valid never high.
//  3 Scan order: at floor 0, dir_up=1, pending 4'b1010; model arrival 4 cycles per floor
//    -> served 1, 3, then no reversal; add req floor 2 while at 3 -> dir_up=0, served 2.
//  4 En-route pickup: travelling 0->3, req floor 2 when current_floor=1 -> target_floor becomes 2, served before 3.
//  5 Emergency: emergency_stop high during DOOR at floor 1, req floor 3 while halted
//    -> door_open=0 and target_valid=0 next cycle, pending[3]=1; release -> IDLE then TRAVEL to 3.
//  6 Park (LIFT_HOME_PARK_EN): idle at floor 2 with no requests for 64 cycles
//    -> target_floor=0, target_valid=1, dir_up=0; arrival -> no door open.

Source files
------------

// File: rtl/lift_pkg.sv
// Shared lift definitions: FSM state encoding, default floor geometry and SCAN target selection.
// Also imported by the lift motion controller.
package lift_pkg;

    localparam int unsigned NUM_FLOORS_DEFAULT = 4;
    localparam int unsigned FLOOR_W_DEFAULT    = 2;

    // Widest configuration nearest_ahead can search
    localparam int unsigned MAX_FLOORS = 32;
    localparam int unsigned MAX_FW     = 5;

    typedef enum logic [1:0] {
        IDLE,
        TRAVEL,
        DOOR,
        HALT
    } lift_state_t;

    typedef struct packed {
        logic              found;
        logic [MAX_FW-1:0] idx;
    } scan_t;

    // Closest pending floor strictly beyond 'floor_pos' in the scan direction
    function automatic scan_t nearest_ahead(input logic [MAX_FLOORS-1:0] pend,
                                            input logic [MAX_FW-1:0]     floor_pos,
                                            input logic                  up);
        scan_t r;
        r = '0;
        for (int unsigned i = 0; i < MAX_FLOORS; i++) begin
            if (up) begin
                if (!r.found && pend[i] && (i > 32'(floor_pos))) begin
                    r.found = 1'b1;
                    r.idx   = MAX_FW'(i);
                end
            end else if (pend[i] && (i < 32'(floor_pos))) begin
                r.found = 1'b1;
                r.idx   = MAX_FW'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/lift_dwell_timer.sv
// Door dwell down-counter: load/reload starts a DOOR_CYCLES dwell, expired marks its final cycle.
module lift_dwell_timer #(
    parameter int unsigned DOOR_CYCLES = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic clear,
    output logic expired
);

    localparam int unsigned CW = $clog2(DOOR_CYCLES + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            count <= '0;
        end else if (load) begin
            count <= CW'(DOOR_CYCLES);
        end else if (count != '0) begin
            count <= count - CW'(1);
        end
    end

    assign expired = (count == CW'(1));

endmodule

// File: rtl/lift_request_scheduler.sv
// SCAN (collective) lift scheduler: latches floor calls, selects targets, times the door dwell.
// Optional homing to floor 0 after a long idle period is enabled by defining LIFT_HOME_PARK_EN.
module lift_request_scheduler
    import lift_pkg::*;
#(
    parameter int unsigned NUM_FLOORS  = NUM_FLOORS_DEFAULT,
    parameter int unsigned FLOOR_W     = FLOOR_W_DEFAULT,
    parameter int unsigned DOOR_CYCLES = 8,
    parameter int unsigned PARK_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_FLOORS-1:0] floor_req,
    input  logic                  emergency_stop,
    input  logic [FLOOR_W-1:0]    current_floor,
    input  logic                  at_floor,
    output logic [FLOOR_W-1:0]    target_floor,
    output logic                  target_valid,
    output logic                  dir_up,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pending
);

    if (((2 ** FLOOR_W) < NUM_FLOORS) || (NUM_FLOORS > MAX_FLOORS) ||
        (DOOR_CYCLES < 1) || (PARK_CYCLES < 1)) begin : g_bad_cfg
        $error("lift_request_scheduler: unsupported parameter set");
    end

    lift_state_t           state, state_n;
    logic [NUM_FLOORS-1:0] pending_n, cur_mask;
    logic [FLOOR_W-1:0]    tf_n, ahead_floor;
    logic                  tv_n, dir_n, door_n;
    logic                  dwell_load, dwell_clear, dwell_expired;
    logic                  here_pending, req_here, arrived;
    logic                  parking, park_go;
    scan_t                 ahead;

    always_comb begin
        cur_mask = '0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            cur_mask[i] = (32'(current_floor) == i);
        end
    end

    assign ahead        = nearest_ahead(MAX_FLOORS'(pending), MAX_FW'(current_floor), dir_up);
    assign ahead_floor  = FLOOR_W'(ahead.idx);
    assign here_pending = |(pending & cur_mask);
    assign req_here     = |(floor_req & cur_mask);
    assign arrived      = at_floor && (current_floor == target_floor);

`ifdef LIFT_HOME_PARK_EN
    localparam int unsigned PW = $clog2(PARK_CYCLES + 1);

    logic [PW-1:0] idle_cnt;

    assign park_go = (state == IDLE) && (pending == '0) && (floor_req == '0) &&
                     (current_floor != '0) && (idle_cnt == PW'(PARK_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            idle_cnt <= '0;
            parking  <= 1'b0;
        end else begin
            if ((state != IDLE) || (pending != '0) || (floor_req != '0) || emergency_stop || park_go) begin
                idle_cnt <= '0;
            end else if (idle_cnt != PW'(PARK_CYCLES - 1)) begin
                idle_cnt <= idle_cnt + PW'(1);
            end
            if (park_go) begin
                parking <= 1'b1;
            end else if (state_n != TRAVEL) begin
                parking <= 1'b0;
            end
        end
    end
`else
    assign park_go = 1'b0;
    assign parking = 1'b0;
`endif

    always_comb begin
        state_n     = state;
        pending_n   = pending | floor_req;
        tf_n        = target_floor;
        tv_n        = target_valid;
        dir_n       = dir_up;
        door_n      = door_open;
        dwell_load  = 1'b0;
        dwell_clear = 1'b0;
        if (emergency_stop) begin
            state_n     = HALT;
            tv_n        = 1'b0;
            door_n      = 1'b0;
            dwell_clear = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (here_pending && at_floor) begin
                        state_n = DOOR;
                    end else if (ahead.found) begin
                        state_n = TRAVEL;
                        tf_n    = ahead_floor;
                        tv_n    = 1'b1;
                    end else if (pending != '0) begin
                        dir_n = !dir_up;
                    end else if (park_go) begin
                        state_n = TRAVEL;
                        tf_n    = '0;
                        tv_n    = 1'b1;
                        dir_n   = 1'b0;
                    end
                end
                TRAVEL: begin
                    // A homing trip never opens the door and yields to any real call
                    if (parking && ((pending != '0) || arrived)) begin
                        state_n = IDLE;
                        tv_n    = 1'b0;
                    end else if (arrived) begin
                        state_n = DOOR;
                    end else if (ahead.found) begin
                        tf_n = ahead_floor;
                    end
                end
                DOOR: begin
                    if (req_here) begin
                        dwell_load = 1'b1;
                    end else if (dwell_expired) begin
                        door_n = 1'b0;
                        if (ahead.found) begin
                            state_n = TRAVEL;
                            tf_n    = ahead_floor;
                            tv_n    = 1'b1;
                        end else begin
                            state_n = IDLE;
                            if (pending != '0) begin
                                dir_n = !dir_up;
                            end
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
        // Serving a floor always wins over a call for it arriving in the same cycle
        if (state_n == DOOR) begin
            pending_n = pending_n & ~cur_mask;
        end
        if ((state_n == DOOR) && (state != DOOR)) begin
            door_n     = 1'b1;
            tv_n       = 1'b0;
            dwell_load = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            pending      <= '0;
            target_floor <= '0;
            target_valid <= 1'b0;
            dir_up       <= 1'b1;
            door_open    <= 1'b0;
        end else begin
            state        <= state_n;
            pending      <= pending_n;
            target_floor <= tf_n;
            target_valid <= tv_n;
            dir_up       <= dir_n;
            door_open    <= door_n;
        end
    end

    lift_dwell_timer #(
        .DOOR_CYCLES(DOOR_CYCLES)
    ) u_dwell (
        .clk    (clk),
        .reset_n(reset_n),
        .load   (dwell_load),
        .clear  (dwell_clear),
        .expired(dwell_expired)
    );

endmodule
